// File: rtl/tdc_therm_decoder.sv
// Thermometer-to-binary fine-time decoder for a 400-tap TDC delay line, fixed 4-stage latency.
// Optional majority bubble filter on the sampled code: define TDC_BUBBLE_FIX_EN.
module tdc_therm_decoder #(
    parameter int unsigned TAP_NUM  = 400,
    parameter int unsigned SEG_W    = 20,
    parameter int unsigned CODE_W   = 9,
    parameter int unsigned DEAD_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TAP_NUM-1:0] step_data,
    input  logic               arm_en,
    output logic [CODE_W-1:0]  fine_code,
    output logic               fine_valid,
    output logic               range_err,
    output logic               hit_drop,
    output logic               busy
);

    localparam int unsigned NSEG   = TAP_NUM / SEG_W;
    localparam int unsigned SEG_CW = $clog2(SEG_W + 1);
    localparam int unsigned ZCNT_W = $clog2(DEAD_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ZCNT_W-1:0]   zcnt_q, zcnt_d;
    logic [TAP_NUM-1:0]  s1_data;
    logic                prev_tap0;
    logic [TAP_NUM-1:0]  s2_data;
    logic [TAP_NUM-1:0]  filt_c;
    logic                hit_c, hit_acc_c, hit_drop_c;
    logic                hit_acc2, hit_acc3;
    logic [SEG_CW-1:0]   seg_cnt_c [NSEG];
    logic [SEG_CW-1:0]   s3_cnt [NSEG];
    logic [CODE_W-1:0]   sum_c;

    assign hit_c = s1_data[0] & ~prev_tap0;

    // Bubble filter: 3-tap majority, end taps passed through
    always_comb begin
        filt_c = s1_data;
`ifdef TDC_BUBBLE_FIX_EN
        for (int i = 1; i < int'(TAP_NUM) - 1; i++) begin
            filt_c[i] = (s1_data[i-1] & s1_data[i]) | (s1_data[i] & s1_data[i+1]) |
                        (s1_data[i-1] & s1_data[i+1]);
        end
`endif
    end

    // FSM next state; evaluated on S1 data
    always_comb begin
        state_d    = state_q;
        zcnt_d     = zcnt_q;
        hit_acc_c  = 1'b0;
        hit_drop_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm_en) state_d = ARMED;
            end
            ARMED: begin
                if (hit_c) begin
                    hit_acc_c = 1'b1;
                    state_d   = BUSY;
                    zcnt_d    = '0;
                end
            end
            BUSY: begin
                if (hit_c) begin
                    hit_drop_c = 1'b1;
                    zcnt_d     = '0;
                end else if (s1_data[0]) begin
                    zcnt_d = '0;
                end else if (zcnt_q == ZCNT_W'(DEAD_CYC - 1)) begin
                    zcnt_d  = '0;
                    state_d = ARMED;
                end else begin
                    zcnt_d = zcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!arm_en) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            zcnt_q   <= '0;
            busy     <= 1'b0;
            hit_drop <= 1'b0;
            hit_acc2 <= 1'b0;
        end else begin
            state_q  <= state_d;
            zcnt_q   <= zcnt_d;
            busy     <= (state_d == BUSY);
            hit_drop <= hit_drop_c;
            hit_acc2 <= hit_acc_c;
        end
    end

    // First-level segment popcounts on S2 data
    always_comb begin
        for (int s = 0; s < int'(NSEG); s++) begin
            seg_cnt_c[s] = '0;
            for (int b = 0; b < int'(SEG_W); b++) begin
                seg_cnt_c[s] = seg_cnt_c[s] + SEG_CW'(s2_data[s*int'(SEG_W) + b]);
            end
        end
    end

    always_comb begin
        sum_c = '0;
        for (int s = 0; s < int'(NSEG); s++) begin
            sum_c = sum_c + CODE_W'(s3_cnt[s]);
        end
    end

    // Data pipeline S1..S4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data    <= '0;
            prev_tap0  <= 1'b0;
            s2_data    <= '0;
            hit_acc3   <= 1'b0;
            for (int s = 0; s < int'(NSEG); s++) s3_cnt[s] <= '0;
            fine_code  <= '0;
            fine_valid <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            s1_data    <= step_data;
            prev_tap0  <= s1_data[0];
            s2_data    <= filt_c;
            hit_acc3   <= hit_acc2;
            for (int s = 0; s < int'(NSEG); s++) s3_cnt[s] <= seg_cnt_c[s];
            fine_valid <= hit_acc3;
            if (hit_acc3) begin
                fine_code <= sum_c;
                range_err <= (sum_c == CODE_W'(TAP_NUM));
            end
        end
    end

endmodule
